aes_tx_serializer: RTL and testbench

AES_TX_SERIALIZER -- requirements
Module: aes_tx_serializer

---
 rtl/aes_uart_pkg.sv | 25 ++
 rtl/aes_blk_fifo.sv | 65 ++++++
 rtl/aes_tx_serializer.sv | 112 +++++++++++
 tb/tb_aes_tx_serializer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES-result UART serializer:
// FSM state encoding, block/CRC constants and a CRC-8 byte update helper.
package aes_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE
    } tx_state_e;

    localparam int         BLOCK_BYTES = 16;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    // MSB-first CRC-8, no reflection; feed bytes in transmit order.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH x WIDTH block FIFO with wrap-around pointers and an explicit occupancy
// counter; a push while full is refused even if a pop happens the same cycle.
module aes_blk_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: combinational blocks assign a default first so no path leaves count_d unassigned (no latch).
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/aes_tx_serializer.sv
// Buffers 128-bit AES results and streams them byte-by-byte to a UART transmitter.
// Optional `AES_TX_SERIALIZER_CRC_EN appends a CRC-8 byte after the 16 data bytes.
module aes_tx_serializer
    import aes_uart_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    input  logic [127:0] blk_data,
    output logic         blk_ready,
    output logic         tx_dv,
    output logic [7:0]   tx_byte,
    input  logic         tx_active,
    input  logic         tx_done,
    output logic         busy,
    output logic         overflow
);

`ifdef AES_TX_SERIALIZER_CRC_EN
    localparam int FRAME_BYTES = BLOCK_BYTES + 1;
`else
    localparam int FRAME_BYTES = BLOCK_BYTES;
`endif

    tx_state_e              state_q;
    logic [127:0]           shift_q;
    logic [4:0]             cnt_q;
    logic                   overflow_q;
    logic [127:0]           fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_pop;
    logic [7:0]             data_byte;

    aes_blk_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (128)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (blk_valid),
        .din_i   (blk_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_pop  = (state_q == LOAD);
    assign blk_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q != IDLE);
    assign overflow  = overflow_q;
    assign data_byte = MSB_FIRST ? shift_q[127:120] : shift_q[7:0];
    // Strobe fires in the SEND cycle that finds the transmitter free, so it lasts one cycle.
    assign tx_dv     = (state_q == SEND) && !tx_active;

`ifdef AES_TX_SERIALIZER_CRC_EN
    logic [7:0] crc_q;

    assign tx_byte = (cnt_q == 5'(BLOCK_BYTES)) ? crc_q : data_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (state_q == LOAD) begin
            crc_q <= '0;
        end else if (tx_dv && (cnt_q < 5'(BLOCK_BYTES))) begin
            crc_q <= crc8_update(crc_q, data_byte);
        end
    end
`else
    assign tx_byte = data_byte;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (blk_valid && fifo_full) overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) state_q <= LOAD;
                end
                LOAD: begin
                    shift_q <= fifo_dout;
                    cnt_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (!tx_active) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        shift_q <= MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
                        cnt_q   <= cnt_q + 5'd1;
                        state_q <= ((cnt_q + 5'd1) < 5'(FRAME_BYTES)) ? SEND : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_tx_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share stimulus;
// expected bytes come from a frame/CRC reference model, a monitor pops and compares.
module tb_aes_tx_serializer;

    localparam int DEPTH = 2;
`ifdef AES_TX_SERIALIZER_CRC_EN
    localparam int FRAME = 17;
`else
    localparam int FRAME = 16;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         blk_valid = 1'b0;
    logic [127:0] blk_data  = '0;
    logic         force_active = 1'b0;

    logic [1:0] blk_ready_w;
    logic [1:0] tx_dv_w;
    logic [1:0] busy_w;
    logic [1:0] overflow_w;
    logic [1:0] tx_active_w;
    logic [1:0] tx_done_w = '0;
    logic [7:0] tx_byte_w [2];

    always #5 clk = ~clk;

    aes_tx_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(blk_ready_w[0]), .tx_dv(tx_dv_w[0]), .tx_byte(tx_byte_w[0]),
        .tx_active(tx_active_w[0]), .tx_done(tx_done_w[0]), .busy(busy_w[0]),
        .overflow(overflow_w[0])
    );

    aes_tx_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(blk_ready_w[1]), .tx_dv(tx_dv_w[1]), .tx_byte(tx_byte_w[1]),
        .tx_active(tx_active_w[1]), .tx_done(tx_done_w[1]), .busy(busy_w[1]),
        .overflow(overflow_w[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    function automatic logic [7:0] frame_byte(input logic [127:0] d, input bit msb, input int i);
        return msb ? d[127 - 8*i -: 8] : d[8*i +: 8];
    endfunction

    // CRC as the remainder of (message * x^8) divided by x^8 + x^2 + x + 1.
    function automatic logic [7:0] crc_ref(input logic [127:0] d, input bit msb);
        logic [135:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[135 - 8*i -: 8] = frame_byte(d, msb, i);
        for (int b = 135; b >= 8; b--) begin
            if (m[b]) m[b -: 9] = m[b -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction

    function automatic int exp_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [7:0] exp_pop(input int k);
        if (k == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic expect_block(input logic [127:0] d);
        for (int i = 0; i < 16; i++) begin
            exp_q0.push_back(frame_byte(d, 1'b1, i));
            exp_q1.push_back(frame_byte(d, 1'b0, i));
        end
        if (FRAME == 17) begin
            exp_q0.push_back(crc_ref(d, 1'b1));
            exp_q1.push_back(crc_ref(d, 1'b0));
        end
    endtask

    // ---------------- monitor ----------------
    int         dv_cnt   [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         pos      [2] = '{0, 0};
    int         starts   [2] = '{0, 0};
    logic [1:0] outstanding = '0;
    logic [7:0] held [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                outstanding[k] = 1'b0;
                pos[k] = 0;
            end else begin
                if (tx_done_w[k] && outstanding[k]) begin
                    check($sformatf("byte_stable[%0d]", k), {24'd0, tx_byte_w[k]}, {24'd0, held[k]});
                    outstanding[k] = 1'b0;
                    done_cnt[k]++;
                end
                if (tx_dv_w[k]) begin
                    dv_cnt[k]++;
                    if (pos[k] == 0) starts[k]++;
                    pos[k] = (pos[k] + 1) % FRAME;
                    if (exp_size(k) == 0)
                        check($sformatf("spurious_dv[%0d]", k), {31'd0, tx_dv_w[k]}, 32'd0);
                    else
                        check($sformatf("tx_byte[%0d]", k), {24'd0, tx_byte_w[k]}, {24'd0, exp_pop(k)});
                    outstanding[k] = 1'b1;
                    held[k] = tx_byte_w[k];
                end
            end
        end
    end

    // ---------------- UART model: tx_done 10 cycles after tx_dv ----------------
    int         uart_cnt [2] = '{0, 0};
    int         seen_dv  [2] = '{0, 0};
    logic [1:0] uart_busy = '0;

    assign tx_active_w = uart_busy | {2{force_active}};

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            tx_done_w[k] = 1'b0;
            if (seen_dv[k] != dv_cnt[k]) begin
                seen_dv[k]   = dv_cnt[k];
                uart_cnt[k]  = 10;
                uart_busy[k] = 1'b1;
            end else if (uart_cnt[k] > 0) begin
                uart_cnt[k]--;
                if (uart_cnt[k] == 0) begin
                    tx_done_w[k] = 1'b1;
                    uart_busy[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [127:0] d);
        blk_data  = d;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((busy_w != 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, {30'd0, busy_w}, 32'd0);
        check({name, "_drain"}, exp_q0.size() + exp_q1.size(), 32'd0);
        repeat (15) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int n;
        int lat;
        int base0;
        int base1;
        int acc;
        int st_base;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_dv", {30'd0, tx_dv_w}, 32'd0);
        check("rst_busy", {30'd0, busy_w}, 32'd0);
        check("rst_ready", {30'd0, blk_ready_w}, 32'd3);
        check("rst_overflow", {30'd0, overflow_w}, 32'd0);
        check("rst_tx_byte", {16'd0, tx_byte_w[0], tx_byte_w[1]}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known vector and first-byte latency
        d = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        expect_block(d);
        issue(d);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (tx_dv_w[0]) break;
        end
        check("latency", lat, 32'd2);
        wait_idle("single", 600);

        // Overflow: two accepted behind a frame in flight, third dropped
        d = rand_block();
        expect_block(d);
        issue(d);
        n = 0;
        while (!tx_dv_w[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ovf_first_dv", {31'd0, tx_dv_w[0]}, 32'd1);
        @(posedge clk); #1;
        d = rand_block();
        expect_block(d);
        blk_data  = d;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        d = rand_block();
        expect_block(d);
        blk_data = d;
        @(posedge clk); #1;
        check("ovf_ready_full", {30'd0, blk_ready_w}, 32'd0);
        check("ovf_before_drop", {30'd0, overflow_w}, 32'd0);
        blk_data = rand_block();
        @(posedge clk); #1;
        blk_valid = 1'b0;
        check("ovf_set", {30'd0, overflow_w}, 32'd3);
        check("ovf_ready_still_full", {30'd0, blk_ready_w}, 32'd0);
        wait_idle("overflow", 2000);
        check("ovf_sticky", {30'd0, overflow_w}, 32'd3);
        check("ready_after_drain", {30'd0, blk_ready_w}, 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("ovf_cleared", {30'd0, overflow_w}, 32'd0);

        // Transmitter held busy: no strobe until it frees up, then exactly one
        force_active = 1'b1;
        d = rand_block();
        expect_block(d);
        issue(d);
        base0 = dv_cnt[0];
        base1 = dv_cnt[1];
        repeat (50) @(posedge clk);
        #1;
        check("hold_no_dv", (dv_cnt[0] - base0) + (dv_cnt[1] - base1), 32'd0);
        check("hold_busy", {30'd0, busy_w}, 32'd3);
        force_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_one_dv_msb", dv_cnt[0] - base0, 32'd1);
        check("hold_one_dv_lsb", dv_cnt[1] - base1, 32'd1);
        wait_idle("hold", 600);

        // Reset after byte 5 abandons the frame
        d = rand_block();
        expect_block(d);
        issue(d);
        base0 = done_cnt[0];
        n = 0;
        while ((done_cnt[0] - base0) < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte5", done_cnt[0] - base0, 32'd5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1;
        check("midrst_tx_dv", {30'd0, tx_dv_w}, 32'd0);
        check("midrst_busy", {30'd0, busy_w}, 32'd0);
        check("midrst_ready", {30'd0, blk_ready_w}, 32'd3);
        rst_n = 1'b1;
        base0 = dv_cnt[0];
        base1 = dv_cnt[1];
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_dv", (dv_cnt[0] - base0) + (dv_cnt[1] - base1), 32'd0);
        d = rand_block();
        expect_block(d);
        issue(d);
        wait_idle("after_reset", 600);

        // CRC-oriented vectors (plain frames when CRC is disabled)
        expect_block(128'h0);
        issue(128'h0);
        d = 128'h000102030405060708090a0b0c0d0e01;
        expect_block(d);
        issue(d);
        wait_idle("crc_vectors", 1200);

        // Random blocks, paced so the model never pushes into a full FIFO
        acc = 0;
        st_base = starts[0];
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            n = 0;
            while ((acc - (starts[0] - st_base)) >= DEPTH && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            d = rand_block();
            expect_block(d);
            issue(d);
            acc++;
        end
        wait_idle("random", 4000);
        check("random_frames", starts[0] - st_base, 32'd8);
        check("random_no_ovf", {30'd0, overflow_w}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
